m_dm: RTL and testbench
=======================

// Module: m_dm
// PURPOSE
//  M-stage data memory: word array with byte-lane stores (sw/sh/sb) and sign/zero-extended loads (lw/lh/lhu/lb/lbu).
//  Driven by E->M pipeline register outputs (ALU result as address, forwarded rt as store data, ctrl bits).
//  RData feeds the DMIn input of the M->W pipeline register; trace port feeds the testbench write log.
// PARAMETERS
//  DEPTH_WORDS  3072      number of 32-bit words; byte address range [0, 4*DEPTH_WORDS)
//  ADDR_W       12        word-index width, must satisfy 2**ADDR_W >= DEPTH_WORDS
// PORTS
//  Clk          in   1   clock, all writes on rising edge
//  Reset        in   1   synchronous, active-high
//  PC           in   32  PC of instruction in M stage (trace only)
//  Addr         in   32  byte address (ALU result)
//  WData        in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  MemWrite     in   1   ctrl bit 30: store enable
//  MemType      in   2   ctrl bits 18:17: 00 word, 01 half, 10 byte, 11 reserved
//  LoadUnsigned in   1   1 = zero-extend sub-word load (lhu/lbu), 0 = sign-extend
//  RData        out  32  extracted, extended load data (combinational)
//  WrEn         out  1   trace: a store commits at next edge
//  WrPC         out  32  trace: PC of committing store
//  WrAddr       out  32  trace: word-aligned byte address ({Addr[31:2],2'b00})
//  WrWord       out  32  trace: full merged word as it will be written
//  Misalign     out  1   access not naturally aligned for MemType
// BEHAVIOUR
//  - Reset: at the edge with Reset=1 every word clears to 0; no store commits that cycle; while Reset=1, WrEn=0, WrPC/WrAddr/WrWord=0.
//  - Reads: zero latency, combinational from array + Addr + MemType + LoadUnsigned; after reset RData=0 for any address.
//  - Word index = Addr[ADDR_W+1:2]; InRange = Addr < 4*DEPTH_WORDS. Out of range: RData=0, store suppressed.
//  - Alignment: word needs Addr[1:0]=00; half needs Addr[0]=0; byte always aligned. MemType=11 treated as misaligned.
//  - Misalign=1 -> store suppressed (WrEn=0), RData=0. No exception raised (no exception path in this pipeline).
//  - Byte enables: word 1111; half Addr[1]?1100:0011; byte one-hot 1<<Addr[1:0].
//  - Store lane placement: half -> WData[15:0] into lanes {3,2} or {1,0}; byte -> WData[7:0] into selected lane.
//  - WrWord = old word with enabled lanes replaced; same value written into array at the edge.
//  - WrEn = MemWrite & InRange & ~Misalign & ~Reset; array writes only when WrEn=1.
//  - Load extract: select half by Addr[1], byte by Addr[1:0]; extend to 32 per LoadUnsigned; word passes through.
//  - Read during write same cycle/same word: RData returns the pre-write contents; new value visible next cycle.
//  - MemWrite with load MemType semantics undefined by ctrl; LoadUnsigned ignored when MemWrite=1 (RData still valid).
//  - Reset asserted on a cycle with MemWrite=1: reset wins, memory cleared, no trace entry.
// STRUCTURE
//  - header.v: `MT_WORD 2'b00, `MT_HALF 2'b01, `MT_BYTE 2'b10 and ctrl-bit positions shared with pipeline regs/controller.
//  - Sub-module dm_ext (combinational): Addr[1:0], MemType, LoadUnsigned, raw word -> RData; reused by no other block.
//  - Byte-enable + merge logic and array kept in m_dm.
// TESTING
//  1. Reset then lw at 0x0000, 0x2FFC -> RData=0x00000000; WrEn=0 throughout reset.
//  2. sw 0x12345678 @0x0010, next cycle lw @0x0010 -> 0x12345678; trace WrAddr=0x10 WrWord=0x12345678.
//  3. Over word 0x12345678 @0x10: sb 0xAB @0x11 -> word 0x1234AB78; lb @0x11 -> 0xFFFFFFAB; lbu -> 0x000000AB.
//  4. sh 0x8001 @0x12 -> word 0x8001AB78; lh @0x12 -> 0xFFFF8001; lhu -> 0x00008001; lh @0x10 -> 0xFFFFAB78.
//  5. sw @0x0013 and sh @0x0011 -> Misalign=1, WrEn=0, memory unchanged; sw @0x3000 (out of range) -> no write, RData=0.
//  6. sw 0xDEADBEEF @0x20 with lw same cycle -> RData=old value; Reset mid-sequence with MemWrite=1 -> all words 0, no trace.

Source files
------------

// File: rtl/m_dm_pkg.sv
// rtl/m_dm_pkg.sv - shared memory-access types, ctrl-bit positions and lane helpers
package m_dm_pkg;

  typedef enum logic [1:0] {
    MT_WORD = 2'b00,
    MT_HALF = 2'b01,
    MT_BYTE = 2'b10,
    MT_RSVD = 2'b11
  } mem_type_e;

  // Positions of the memory ctrl bits inside the pipeline ctrl word
  localparam int CTRL_MEMWRITE_BIT = 30;
  localparam int CTRL_MEMTYPE_MSB  = 18;
  localparam int CTRL_MEMTYPE_LSB  = 17;

  function automatic logic is_misaligned(input mem_type_e mt, input logic [1:0] off);
    case (mt)
      MT_WORD: is_misaligned = (off != 2'b00);
      MT_HALF: is_misaligned = off[0];
      MT_BYTE: is_misaligned = 1'b0;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input mem_type_e mt, input logic [1:0] off);
    case (mt)
      MT_WORD: byte_enables = 4'b1111;
      MT_HALF: byte_enables = off[1] ? 4'b1100 : 4'b0011;
      MT_BYTE: byte_enables = 4'b0001 << off;
      default: byte_enables = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dm_ext.sv
// rtl/dm_ext.sv - load-data extraction: lane select and sign/zero extension
module dm_ext
  import m_dm_pkg::*;
(
  input  logic [1:0]  byte_off_i,
  input  logic [1:0]  mem_type_i,
  input  logic        load_unsigned_i,
  input  logic [31:0] word_i,
  output logic [31:0] rdata_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
    case (byte_off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
  end

  always_comb begin
    rdata_o = '0;
    case (mem_type_e'(mem_type_i))
      MT_WORD: rdata_o = word_i;
      MT_HALF: rdata_o = {{16{half_sel[15] & ~load_unsigned_i}}, half_sel};
      MT_BYTE: rdata_o = {{24{byte_sel[7] & ~load_unsigned_i}}, byte_sel};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/m_dm.sv
// rtl/m_dm.sv - M-stage data memory with byte-lane stores, extended loads and a write trace
module m_dm
  import m_dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int ADDR_W      = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic        MemWrite,
  input  logic [1:0]  MemType,
  input  logic        LoadUnsigned,
  output logic [31:0] RData,
  output logic        WrEn,
  output logic [31:0] WrPC,
  output logic [31:0] WrAddr,
  output logic [31:0] WrWord,
  output logic        Misalign
);

  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0]       mem_q [DEPTH_WORDS];
  mem_type_e         mem_type;
  logic [1:0]        byte_off;
  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic              misalign;
  logic [31:0]       raw_word;
  logic [31:0]       ext_word;
  logic [3:0]        byte_en;
  logic [31:0]       lane_data;
  logic [31:0]       merged_word;
  logic              wr_en;

  assign mem_type = mem_type_e'(MemType);
  assign byte_off = Addr[1:0];
  assign word_idx = Addr[ADDR_W+1:2];
  assign in_range = (Addr < BYTE_LIMIT);
  assign misalign = is_misaligned(mem_type, byte_off);
  assign raw_word = in_range ? mem_q[word_idx] : '0;
  assign byte_en  = byte_enables(mem_type, byte_off);

  // Store data is right-aligned; replicate it so every enabled lane sees its slice
  always_comb begin
    case (mem_type)
      MT_WORD: lane_data = WData;
      MT_HALF: lane_data = {2{WData[15:0]}};
      default: lane_data = {4{WData[7:0]}};
    endcase
  end

  always_comb begin
    merged_word = raw_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        merged_word[8*i +: 8] = lane_data[8*i +: 8];
      end
    end
  end

  assign wr_en = MemWrite & in_range & ~misalign & ~Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[word_idx] <= merged_word;
    end
  end

  dm_ext u_ext (
    .byte_off_i      (byte_off),
    .mem_type_i      (MemType),
    .load_unsigned_i (LoadUnsigned),
    .word_i          (raw_word),
    .rdata_o         (ext_word)
  );

  assign RData    = (in_range && !misalign) ? ext_word : '0;
  assign Misalign = misalign;
  assign WrEn     = wr_en;
  assign WrPC     = Reset ? '0 : PC;
  assign WrAddr   = Reset ? '0 : {Addr[31:2], 2'b00};
  assign WrWord   = Reset ? '0 : merged_word;

endmodule

// File: tb/tb_m_dm.sv
// tb/tb_m_dm.sv - directed vector table plus randomized checks against a byte-array model
module tb_m_dm;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PC, Addr, WData;
  logic        MemWrite, LoadUnsigned;
  logic [1:0]  MemType;
  logic [31:0] RData, WrPC, WrAddr, WrWord;
  logic        WrEn, Misalign;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  m_dm dut (
    .Clk(Clk), .Reset(Reset), .PC(PC), .Addr(Addr), .WData(WData),
    .MemWrite(MemWrite), .MemType(MemType), .LoadUnsigned(LoadUnsigned),
    .RData(RData), .WrEn(WrEn), .WrPC(WrPC), .WrAddr(WrAddr), .WrWord(WrWord),
    .Misalign(Misalign)
  );

  typedef struct {
    logic        rst;
    logic        mw;
    logic [1:0]  mt;
    logic        lu;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wren;
    logic        mis;
    logic [31:0] wrword;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] ref_mem [12288];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d] got=%08h expected=%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic mw, input logic [1:0] mt, input logic lu,
                       input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wdata);
    Reset = rst; MemWrite = mw; MemType = mt; LoadUnsigned = lu;
    PC = pc; Addr = addr; WData = wdata;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic vec_t v(input logic rst, input logic mw, input logic [1:0] mt, input logic lu,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic wren, input logic mis, input logic [31:0] wrword);
    vec_t r;
    r.rst = rst; r.mw = mw; r.mt = mt; r.lu = lu; r.addr = addr; r.wdata = wdata;
    r.rdata = rdata; r.wren = wren; r.mis = mis; r.wrword = wrword;
    return r;
  endfunction

  // Reference: memory as a flat byte array, little-endian, sizes 4/2/1
  function automatic int unsigned acc_size(input logic [1:0] mt);
    return (mt == 2'd0) ? 4 : (mt == 2'd1) ? 2 : 1;
  endfunction

  function automatic logic ref_mis(input logic [1:0] mt, input logic [31:0] addr);
    if (mt == 2'd3) return 1'b1;
    return (addr % acc_size(mt)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] mt, input logic lu, input logic [31:0] addr);
    int unsigned sz;
    logic [31:0] val;
    if (addr >= 32'd12288 || ref_mis(mt, addr)) return 32'd0;
    sz = acc_size(mt);
    val = 0;
    for (int k = 0; k < sz; k++) val = val | (32'(ref_mem[addr + k]) << (8 * k));
    if (!lu && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8 * sz));
    return val;
  endfunction

  initial begin
    Reset = 1'b1; MemWrite = 1'b0; MemType = 2'd0; LoadUnsigned = 1'b0;
    PC = '0; Addr = '0; WData = '0;
    tick();

    //          rst mw mt    lu addr          wdata          rdata          wren mis wrword
    vecs.push_back(v(1, 1, 2'd0, 0, 32'h0000_0010, 32'h0000_0001, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_0000, 32'h0,         32'h0000_0000, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_2FFC, 32'h0,         32'h0000_0000, 0, 0, 0));
    vecs.push_back(v(0, 1, 2'd0, 0, 32'h0000_0010, 32'h1234_5678, 32'h0000_0000, 1, 0, 32'h1234_5678));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_0010, 32'h0,         32'h1234_5678, 0, 0, 0));
    vecs.push_back(v(0, 1, 2'd2, 0, 32'h0000_0011, 32'hCDEF_00AB, 32'h0000_0056, 1, 0, 32'h1234_AB78));
    vecs.push_back(v(0, 0, 2'd2, 0, 32'h0000_0011, 32'h0,         32'hFFFF_FFAB, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd2, 1, 32'h0000_0011, 32'h0,         32'h0000_00AB, 0, 0, 0));
    vecs.push_back(v(0, 1, 2'd1, 0, 32'h0000_0012, 32'h5555_8001, 32'h0000_1234, 1, 0, 32'h8001_AB78));
    vecs.push_back(v(0, 0, 2'd1, 0, 32'h0000_0012, 32'h0,         32'hFFFF_8001, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd1, 1, 32'h0000_0012, 32'h0,         32'h0000_8001, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd1, 0, 32'h0000_0010, 32'h0,         32'hFFFF_AB78, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd2, 0, 32'h0000_0013, 32'h0,         32'hFFFF_FF80, 0, 0, 0));
    vecs.push_back(v(0, 1, 2'd0, 0, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 0));
    vecs.push_back(v(0, 1, 2'd1, 0, 32'h0000_0011, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 0));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_0010, 32'h0,         32'h8001_AB78, 0, 0, 0));
    vecs.push_back(v(0, 1, 2'd0, 0, 32'h0000_3000, 32'h1111_2222, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_3000, 32'h0,         32'h0000_0000, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd3, 0, 32'h0000_0010, 32'h0,         32'h0000_0000, 0, 1, 0));
    vecs.push_back(v(0, 1, 2'd0, 0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0000, 1, 0, 32'hDEAD_BEEF));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 0, 0, 0));
    vecs.push_back(v(0, 1, 2'd0, 0, 32'h0000_2FFC, 32'hCAFE_F00D, 32'h0000_0000, 1, 0, 32'hCAFE_F00D));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_2FFC, 32'h0,         32'hCAFE_F00D, 0, 0, 0));
    vecs.push_back(v(1, 1, 2'd0, 0, 32'h0000_0020, 32'h0000_0001, 32'hDEAD_BEEF, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_0020, 32'h0,         32'h0000_0000, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_0010, 32'h0,         32'h0000_0000, 0, 0, 0));
    vecs.push_back(v(0, 0, 2'd0, 0, 32'h0000_2FFC, 32'h0,         32'h0000_0000, 0, 0, 0));

    foreach (vecs[i]) begin
      logic [31:0] pc;
      pc = 32'h0040_0000 + 32'(4 * i);
      drive(vecs[i].rst, vecs[i].mw, vecs[i].mt, vecs[i].lu, pc, vecs[i].addr, vecs[i].wdata);
      chk("rdata", i, RData, vecs[i].rdata);
      chk("wren", i, 32'(WrEn), 32'(vecs[i].wren));
      chk("misalign", i, 32'(Misalign), 32'(vecs[i].mis));
      if (vecs[i].wren) begin
        chk("wrword", i, WrWord, vecs[i].wrword);
        chk("wraddr", i, WrAddr, vecs[i].addr & 32'hFFFF_FFFC);
        chk("wrpc", i, WrPC, pc);
      end
      if (vecs[i].rst) begin
        chk("rst_wrpc", i, WrPC, 32'd0);
        chk("rst_wraddr", i, WrAddr, 32'd0);
        chk("rst_wrword", i, WrWord, 32'd0);
      end
      tick();
    end

    // Hand-written sequence: same-word store then immediate byte reads across all lanes
    drive(0, 1, 2'd0, 0, 32'h100, 32'h0000_0100, 32'h80FF_7F01);
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_b;
      case (k)
        0: exp_b = 32'h0000_0001;
        1: exp_b = 32'h0000_007F;
        2: exp_b = 32'hFFFF_FFFF;
        default: exp_b = 32'hFFFF_FF80;
      endcase
      drive(0, 0, 2'd2, 0, 32'h0, 32'h100 + 32'(k), 32'h0);
      chk("lane_lb", k, RData, exp_b);
    end
    drive(1, 0, 2'd0, 0, 32'h0, 32'h0, 32'h0);
    tick();

    for (int a = 0; a < 12288; a++) ref_mem[a] = 8'h00;

    for (int n = 0; n < 600; n++) begin
      logic [31:0] addr, wdata, pc, exp_rd, exp_word;
      logic [1:0]  mt;
      logic        mw, lu, exp_mis, exp_we;
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = $urandom;
      else if (sel == 1) addr = 32'h2FF0 + $urandom_range(0, 31);
      else               addr = $urandom_range(0, 63);
      mt = 2'($urandom_range(0, 3));
      mw = 1'($urandom_range(0, 1));
      lu = 1'($urandom_range(0, 1));
      wdata = $urandom;
      pc = $urandom;
      exp_mis = ref_mis(mt, addr);
      exp_rd = ref_load(mt, lu, addr);
      exp_we = mw && addr < 32'd12288 && !exp_mis;
      drive(0, mw, mt, lu, pc, addr, wdata);
      chk("rnd_rdata", n, RData, exp_rd);
      chk("rnd_wren", n, 32'(WrEn), 32'(exp_we));
      chk("rnd_misalign", n, 32'(Misalign), 32'(exp_mis));
      if (exp_we) begin
        for (int k = 0; k < acc_size(mt); k++) ref_mem[addr + k] = wdata[8*k +: 8];
        exp_word = ref_load(2'd0, 1'b0, addr & 32'hFFFF_FFFC);
        chk("rnd_wrword", n, WrWord, exp_word);
        chk("rnd_wraddr", n, WrAddr, addr & 32'hFFFF_FFFC);
        chk("rnd_wrpc", n, WrPC, pc);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
